// File: rtl/nf10_axis_stream_monitor_if.sv
// AXI4-Stream bus bundle observed by nf10_axis_stream_monitor.
// The master drives the payload; the monitor (slave) returns tready.
interface nf10_axis_stream_monitor_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_stream_monitor.sv
// AXI4-Stream sink that generates tready, gathers traffic statistics and flags protocol errors.
// Optional macro NF10_AXIS_MONITOR_TUSER_LEN_CHECK_EN adds the tuser[15:0] length check (err_flags[5]).
module nf10_axis_stream_monitor #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_READY_MODE         = 0,
    parameter int C_STALL_PERIOD       = 8,
    parameter int C_CNT_WIDTH          = 32,
    parameter int C_MAX_PKT_BYTES      = 16383
) (
    input  logic                   aclk,
    input  logic                   reset,
    nf10_axis_stream_monitor_if.slave s_axis,
    input  logic                   clear,
    output logic [C_CNT_WIDTH-1:0] pkt_count,
    output logic [C_CNT_WIDTH-1:0] byte_count,
    output logic [C_CNT_WIDTH-1:0] err_count,
    output logic [7:0]             err_flags,
    output logic                   in_packet
);
    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int POP_W  = $clog2(STRB_W + 1);
    localparam int ACC_W  = 32;
    localparam int SC_W   = $clog2(C_STALL_PERIOD);
    localparam int BEAT_W = C_S_AXIS_DATA_WIDTH + STRB_W + C_S_AXIS_TUSER_WIDTH + 1;

    function automatic logic [POP_W-1:0] popcount(input logic [STRB_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < STRB_W; i++) n = n + POP_W'(v[i]);
        return n;
    endfunction

    logic              run;
    logic [SC_W-1:0]   stall_cnt;
    logic [15:0]       lfsr;
    logic              ready_gen;
    logic              tready_int;
    logic              accept;
    logic [STRB_W-1:0] strb;
    logic [POP_W-1:0]  beat_bytes;
    logic [ACC_W-1:0]  pkt_acc;
    logic [ACC_W:0]    acc_wide;
    logic [ACC_W-1:0]  acc_next;
    logic              oversize_seen;
    logic [BEAT_W-1:0] beat_now;
    logic [BEAT_W-1:0] prev_beat;
    logic              prev_valid;
    logic              prev_accept;
    logic              strb_shape_bad;
    logic              len_err;
    logic [7:0]        events;
    logic [C_CNT_WIDTH:0]   byte_wide;
    logic [C_CNT_WIDTH-1:0] byte_next;

    // run stays low for the first cycle after reset, holding tready low and masking the checks.
    always_ff @(posedge aclk) begin
        if (reset) begin
            run       <= 1'b0;
            stall_cnt <= '0;
            lfsr      <= 16'hACE1;
        end else begin
            run       <= 1'b1;
            stall_cnt <= (stall_cnt == SC_W'(C_STALL_PERIOD - 1)) ? '0 : stall_cnt + SC_W'(1);
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        ready_gen = 1'b1;
        if (C_READY_MODE == 1)
            ready_gen = (stall_cnt != '0);
        else if (C_READY_MODE == 2)
            ready_gen = lfsr[0] | lfsr[1];
    end

    assign tready_int    = run & ready_gen;
    assign s_axis.tready = tready_int;
    assign accept        = s_axis.tvalid & tready_int;

    assign strb           = s_axis.tstrb;
    assign beat_bytes     = popcount(strb);
    assign strb_shape_bad = ((strb & (strb + STRB_W'(1))) != '0);
    assign beat_now       = {s_axis.tdata, s_axis.tstrb, s_axis.tuser, s_axis.tlast};

    assign acc_wide = {1'b0, pkt_acc} + {{(ACC_W + 1 - POP_W){1'b0}}, beat_bytes};
    assign acc_next = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];

`ifdef NF10_AXIS_MONITOR_TUSER_LEN_CHECK_EN
    logic [15:0] len_cap;
    logic [15:0] first_len;

    always_ff @(posedge aclk) begin
        if (reset)
            len_cap <= '0;
        else if (accept && !in_packet)
            len_cap <= s_axis.tuser[15:0];
    end

    // A single-beat packet has no captured length yet, so use the live tuser.
    assign first_len = in_packet ? len_cap : s_axis.tuser[15:0];
    assign len_err   = accept & s_axis.tlast & ({16'b0, first_len} != acc_next);
`else
    assign len_err = 1'b0;
`endif

    always_comb begin
        events    = '0;
        events[0] = run & prev_valid & ~prev_accept & ~s_axis.tvalid;
        events[1] = run & s_axis.tvalid & prev_valid & ~prev_accept & (beat_now != prev_beat);
        events[2] = accept & (strb != '0) & strb_shape_bad;
        events[3] = accept & (strb == '0);
        events[4] = accept & ~oversize_seen & (acc_next > ACC_W'(C_MAX_PKT_BYTES));
        events[5] = len_err;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            prev_valid  <= 1'b0;
            prev_accept <= 1'b0;
            prev_beat   <= '0;
        end else begin
            prev_valid  <= s_axis.tvalid;
            prev_accept <= accept;
            prev_beat   <= beat_now;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            pkt_acc       <= '0;
            in_packet     <= 1'b0;
            oversize_seen <= 1'b0;
        end else if (accept) begin
            if (s_axis.tlast) begin
                pkt_acc       <= '0;
                in_packet     <= 1'b0;
                oversize_seen <= 1'b0;
            end else begin
                pkt_acc   <= acc_next;
                in_packet <= 1'b1;
                if (events[4])
                    oversize_seen <= 1'b1;
            end
        end
    end

    assign byte_wide = {1'b0, byte_count} + {{(C_CNT_WIDTH + 1 - POP_W){1'b0}}, beat_bytes};
    assign byte_next = byte_wide[C_CNT_WIDTH] ? '1 : byte_wide[C_CNT_WIDTH-1:0];

    // clear wins over any beat or error in the same cycle.
    always_ff @(posedge aclk) begin
        if (reset || clear) begin
            pkt_count  <= '0;
            byte_count <= '0;
            err_count  <= '0;
            err_flags  <= '0;
        end else begin
            if (accept) begin
                byte_count <= byte_next;
                if (s_axis.tlast && pkt_count != '1)
                    pkt_count <= pkt_count + C_CNT_WIDTH'(1);
            end
            if ((events != '0) && err_count != '1)
                err_count <= err_count + C_CNT_WIDTH'(1);
            err_flags <= err_flags | events;
        end
    end
endmodule
